// File: rtl/multi_core_mem_arbiter_if.sv
// Core-request / response / RAM-command bundle shared by the arbiter and its environment.
// The slave modport is the arbiter's view; master is the cores-plus-RAM side.
interface multi_core_mem_arbiter_if #(
    parameter int NCORES = 4,
    parameter int XLEN   = 64
);
    localparam int MW = XLEN / 8;

    logic [NCORES-1:0]      req_valid;
    logic [NCORES-1:0]      req_ready;
    logic [2*NCORES-1:0]    req_memop;
    logic [MW*NCORES-1:0]   req_mask;
    logic [XLEN*NCORES-1:0] req_addr;
    logic [XLEN*NCORES-1:0] req_data;

    logic [NCORES-1:0]      resp_valid;
    logic [XLEN-1:0]        resp_data;
    logic                   resp_exception;

    logic                   mem_enable;
    logic [1:0]             mem_memo;
    logic [MW-1:0]          mem_mask;
    logic [XLEN-1:0]        mem_addr;
    logic [XLEN-1:0]        mem_data;
    logic [XLEN-1:0]        mem_resp;
    logic                   mem_exception;

    modport slave (
        input  req_valid, req_memop, req_mask, req_addr, req_data,
        input  mem_resp, mem_exception,
        output req_ready, resp_valid, resp_data, resp_exception,
        output mem_enable, mem_memo, mem_mask, mem_addr, mem_data
    );

    modport master (
        output req_valid, req_memop, req_mask, req_addr, req_data,
        output mem_resp, mem_exception,
        input  req_ready, resp_valid, resp_data, resp_exception,
        input  mem_enable, mem_memo, mem_mask, mem_addr, mem_data
    );
endinterface

// File: rtl/multi_core_mem_arbiter.sv
// Round-robin arbiter giving NCORES cores serialized access to one fixed-latency RAM,
// one transaction in flight at a time.
module multi_core_mem_arbiter #(
    parameter int NCORES  = 4,
    parameter int XLEN    = 64,
    parameter int MEM_LAT = 2
) (
    input  logic clk,
    input  logic reset,
    multi_core_mem_arbiter_if.slave bus
);
    localparam int MW    = XLEN / 8;
    localparam int PTR_W = (NCORES > 1) ? $clog2(NCORES) : 1;

    localparam logic [1:0] OP_RSVD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b10;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   cur_core;
    logic [1:0]         cur_op;
    logic [2:0]         cnt;

    logic               found;
    logic [PTR_W-1:0]   grant;
    logic [PTR_W:0]     idx;
    logic [1:0]         grant_op;

    function automatic logic [NCORES-1:0] onehot(input logic [PTR_W-1:0] i);
        return NCORES'(1) << i;
    endfunction

    // NOTE: every always_comb output gets a default before any conditional write,
    // otherwise synthesis infers a latch to hold the unassigned case.
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = '0;
        for (int i = 0; i < NCORES; i++) begin
            idx = {1'b0, rr_ptr} + (PTR_W+1)'(i);
            if (idx >= (PTR_W+1)'(NCORES))
                idx = idx - (PTR_W+1)'(NCORES);
            if (!found && bus.req_valid[idx[PTR_W-1:0]]) begin
                found = 1'b1;
                grant = idx[PTR_W-1:0];
            end
        end
    end

    assign grant_op      = bus.req_memop[2*grant +: 2];
    // Accept is combinational so a core sees its grant in the cycle it asks.
    assign bus.req_ready = (state == IDLE && !reset && found) ? onehot(grant) : '0;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            rr_ptr             <= '0;
            cur_core           <= '0;
            cur_op             <= '0;
            cnt                <= '0;
            bus.resp_valid     <= '0;
            bus.resp_data      <= '0;
            bus.resp_exception <= 1'b0;
            bus.mem_enable     <= 1'b0;
            bus.mem_memo       <= '0;
            bus.mem_mask       <= '0;
            bus.mem_addr       <= '0;
            bus.mem_data       <= '0;
        end else begin
            bus.mem_enable <= 1'b0;
            bus.resp_valid <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        cur_core <= grant;
                        cur_op   <= grant_op;
                        rr_ptr   <= (grant == PTR_W'(NCORES-1)) ? '0 : grant + 1'b1;
                        if (grant_op == OP_RSVD) begin
                            // Reserved op never reaches the RAM; it answers with an exception.
                            bus.resp_data      <= '0;
                            bus.resp_exception <= 1'b1;
                            bus.resp_valid     <= onehot(grant);
                            state              <= RESP;
                        end else begin
                            bus.mem_enable <= 1'b1;
                            bus.mem_memo   <= grant_op;
                            bus.mem_mask   <= bus.req_mask[MW*grant +: MW];
                            bus.mem_addr   <= bus.req_addr[XLEN*grant +: XLEN];
                            bus.mem_data   <= bus.req_data[XLEN*grant +: XLEN];
                            state          <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    cnt   <= 3'(MEM_LAT - 1);
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt == 3'd0) begin
                        bus.resp_data      <= (cur_op == OP_STORE) ? '0 : bus.mem_resp;
                        bus.resp_exception <= bus.mem_exception;
                        bus.resp_valid     <= onehot(cur_core);
                        state              <= RESP;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multi_core_mem_arbiter.sv
// Self-checking bench: a transaction-timeline model checks every cycle, directed
// scenarios pin literal expectations.
module tb_multi_core_mem_arbiter;
    localparam int NCORES  = 4;
    localparam int XLEN    = 64;
    localparam int MEM_LAT = 2;
    localparam int MW      = XLEN / 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    multi_core_mem_arbiter_if #(.NCORES(NCORES), .XLEN(XLEN)) bus ();

    multi_core_mem_arbiter #(.NCORES(NCORES), .XLEN(XLEN), .MEM_LAT(MEM_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: once a request is accepted at cycle ta, the mem strobe is at ta+1, the RAM
    // value is sampled at ta+1+MEM_LAT and the answer appears at ta+2+MEM_LAT
    // (reserved op: answer at ta+1). Between transactions the block is idle.
    int          cyc = 0;
    bit          t_active = 1'b0;
    int          t_acc, t_resp, t_core;
    logic [1:0]  t_op;
    logic [MW-1:0]   t_mask;
    logic [XLEN-1:0] t_addr, t_data, t_rdata;
    logic            t_rexc;
    int              m_rr = 0;
    logic [XLEN-1:0] exp_rdata = '0;
    logic            exp_rexc  = 1'b0;

    initial begin
        logic [NCORES-1:0] exp_ready, exp_rv;
        logic              exp_me;
        int                g, c;
        @(posedge clk);
        forever begin
            @(negedge clk);
            cyc++;
            exp_ready = '0;
            exp_rv    = '0;
            exp_me    = 1'b0;
            if (t_active) begin
                if (t_op != 2'b00 && cyc == t_acc + 1) begin
                    exp_me = 1'b1;
                    check("model_mem_memo", bus.mem_memo, t_op);
                    check("model_mem_mask", bus.mem_mask, t_mask);
                    check("model_mem_addr", bus.mem_addr, t_addr);
                    check("model_mem_data", bus.mem_data, t_data);
                end
                if (t_op != 2'b00 && cyc == t_acc + 1 + MEM_LAT) begin
                    t_rdata = (t_op == 2'b10) ? '0 : bus.mem_resp;
                    t_rexc  = bus.mem_exception;
                end
                if (cyc == t_resp) begin
                    exp_rv    = NCORES'(1) << t_core;
                    exp_rdata = t_rdata;
                    exp_rexc  = t_rexc;
                end
            end else if (!reset) begin
                g = -1;
                for (int k = 0; k < NCORES; k++) begin
                    c = (m_rr + k) % NCORES;
                    if (g < 0 && bus.req_valid[c]) g = c;
                end
                if (g >= 0) begin
                    exp_ready = NCORES'(1) << g;
                    t_active  = 1'b1;
                    t_acc     = cyc;
                    t_core    = g;
                    t_op      = bus.req_memop[2*g +: 2];
                    t_mask    = bus.req_mask[MW*g +: MW];
                    t_addr    = bus.req_addr[XLEN*g +: XLEN];
                    t_data    = bus.req_data[XLEN*g +: XLEN];
                    t_resp    = (t_op == 2'b00) ? cyc + 1 : cyc + MEM_LAT + 2;
                    if (t_op == 2'b00) begin
                        t_rdata = '0;
                        t_rexc  = 1'b1;
                    end
                    m_rr = (g + 1) % NCORES;
                end
            end
            check("model_req_ready", bus.req_ready, exp_ready);
            check("model_resp_valid", bus.resp_valid, exp_rv);
            check("model_mem_enable", bus.mem_enable, exp_me);
            check("model_resp_data", bus.resp_data, exp_rdata);
            check("model_resp_exception", bus.resp_exception, exp_rexc);
            if (t_active && cyc == t_resp) t_active = 1'b0;
            if (reset) begin
                t_active  = 1'b0;
                m_rr      = 0;
                exp_rdata = '0;
                exp_rexc  = 1'b0;
            end
        end
    end

    // One isolated request from a single core, with literal expected outcome.
    task automatic run_txn(input int core, input logic [1:0] op, input logic [MW-1:0] mask,
                           input logic [XLEN-1:0] addr, input logic [XLEN-1:0] data,
                           input logic [XLEN-1:0] mresp, input logic mexc,
                           input logic [NCORES-1:0] exp_grant,
                           input logic [XLEN-1:0] exp_data, input logic exp_exc);
        bus.req_valid                  = '0;
        bus.req_valid[core]            = 1'b1;
        bus.req_memop[2*core +: 2]     = op;
        bus.req_mask[MW*core +: MW]    = mask;
        bus.req_addr[XLEN*core +: XLEN] = addr;
        bus.req_data[XLEN*core +: XLEN] = data;
        #1 check("accept_ready", bus.req_ready, exp_grant);
        tick();
        bus.req_valid     = '0;
        bus.mem_resp      = 64'hBAD0_BAD0_BAD0_BAD0;
        bus.mem_exception = ~mexc;
        if (op != 2'b00) begin
            check("issue_mem_enable", bus.mem_enable, 1'b1);
            check("issue_mem_memo", bus.mem_memo, op);
            check("issue_mem_mask", bus.mem_mask, mask);
            check("issue_mem_addr", bus.mem_addr, addr);
            check("issue_mem_data", bus.mem_data, data);
            for (int k = 1; k <= MEM_LAT; k++) begin
                tick();
                if (k == MEM_LAT) begin
                    bus.mem_resp      = mresp;
                    bus.mem_exception = mexc;
                end
            end
            tick();
            bus.mem_resp      = 64'hBAD1_BAD1_BAD1_BAD1;
            bus.mem_exception = ~mexc;
        end else begin
            check("rsvd_no_mem_enable", bus.mem_enable, 1'b0);
        end
        check("resp_valid", bus.resp_valid, exp_grant);
        check("resp_data", bus.resp_data, exp_data);
        check("resp_exception", bus.resp_exception, exp_exc);
        tick();
        check("resp_valid_clear", bus.resp_valid, '0);
        check("resp_data_hold", bus.resp_data, exp_data);
    endtask

    initial begin
        int glog[$];
        int gcyc[$];
        bus.req_valid     = '0;
        bus.req_memop     = '0;
        bus.req_mask      = '0;
        bus.req_addr      = '0;
        bus.req_data      = '0;
        bus.mem_resp      = '0;
        bus.mem_exception = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        check("rst_req_ready", bus.req_ready, '0);
        check("rst_resp_valid", bus.resp_valid, '0);
        check("rst_mem_enable", bus.mem_enable, 1'b0);
        check("rst_mem_memo", bus.mem_memo, 2'b00);
        check("rst_mem_mask", bus.mem_mask, '0);
        check("rst_mem_addr", bus.mem_addr, '0);
        check("rst_mem_data", bus.mem_data, '0);
        check("rst_resp_data", bus.resp_data, '0);
        check("rst_resp_exception", bus.resp_exception, 1'b0);
        reset = 1'b0;

        // Core 2 load; rr_ptr starts at 0 and core 2 is the only requester.
        run_txn(2, 2'b01, 8'hFF, 64'h1000, 64'h0, 64'hDEAD_BEEF, 1'b0, 4'b0100, 64'hDEAD_BEEF, 1'b0);
        // Core 3 store with RAM exception: data forced to 0, exception passed.
        run_txn(3, 2'b10, 8'h0F, 64'h2000, 64'h55, 64'hFFFF_0000, 1'b1, 4'b1000, 64'h0, 1'b1);
        // Core 0 alone right after core 3: pointer wrapped, granted immediately.
        run_txn(0, 2'b11, 8'hFF, 64'h3000, 64'hA5, 64'h77, 1'b0, 4'b0001, 64'h77, 1'b0);
        // Core 1 reserved op: answered next cycle with exception, no RAM strobe.
        run_txn(1, 2'b00, 8'h00, 64'h0, 64'h0, 64'h9999, 1'b0, 4'b0010, 64'h0, 1'b1);

        // Core 2 accepted; core 0 raises and drops valid while busy and is never granted.
        bus.req_valid = 4'b0100;
        bus.req_memop = 8'b0001_0000;
        #1 check("drop_accept_ready", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid = 4'b0001;
        bus.req_memop = 8'b0000_0001;
        tick();
        bus.req_valid = '0;
        tick();
        tick();
        tick();
        check("drop_no_grant", bus.req_ready, '0);

        // All cores valid continuously after reset: 0,1,2,3,0 with MEM_LAT+3 spacing.
        reset         = 1'b1;
        bus.req_valid = 4'hF;
        bus.req_memop = 8'b0101_0101;
        bus.mem_resp  = 64'h1234;
        #1 check("rst_cycle_ready", bus.req_ready, '0);
        tick();
        reset = 1'b0;
        for (int n = 0; n < 22; n++) begin
            #1;
            for (int k = 0; k < NCORES; k++)
                if (bus.req_ready[k]) begin
                    glog.push_back(k);
                    gcyc.push_back(n);
                end
            tick();
        end
        bus.req_valid = '0;
        check("rr_grant_count", glog.size() >= 5, 1'b1);
        if (glog.size() >= 5) begin
            check("rr_order0", glog[0], 0);
            check("rr_order1", glog[1], 1);
            check("rr_order2", glog[2], 2);
            check("rr_order3", glog[3], 3);
            check("rr_order4", glog[4], 0);
            for (int i = 1; i < 5; i++)
                check("rr_spacing", gcyc[i] - gcyc[i-1], 5);
        end
        repeat (6) tick();

        // Reset during WAIT: transaction dropped, late RAM data ignored, core 0 first.
        bus.req_valid = 4'b0100;
        bus.req_memop = 8'b0001_0000;
        #1 check("rstwait_accept", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid = '0;
        tick();
        reset         = 1'b1;
        bus.req_valid = 4'hF;
        bus.req_memop = 8'b0101_0101;
        #1 check("rstwait_ready_in_reset", bus.req_ready, '0);
        tick();
        reset             = 1'b0;
        bus.mem_resp      = 64'hAAAA_AAAA_AAAA_AAAA;
        bus.mem_exception = 1'b1;
        #1 check("rstwait_core0_first", bus.req_ready, 4'b0001);
        check("rstwait_no_resp0", bus.resp_valid, '0);
        tick();
        bus.req_valid = '0;
        check("rstwait_no_resp1", bus.resp_valid, '0);
        check("rstwait_data_cleared", bus.resp_data, '0);
        repeat (6) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
